// File: rtl/pong_motion_ctrl_pkg.sv
// Shared geometry, velocity and state definitions for the pong motion controller.
// All coordinate constants are typed 10-bit so datapath compares stay width-matched.
package pong_pkg;

    typedef logic [9:0]        coord_t;
    typedef logic signed [9:0] vel_t;

    localparam coord_t MAX_X      = 10'd640;
    localparam coord_t MAX_Y      = 10'd480;
    localparam coord_t WALL_X_R   = 10'd35;
    localparam coord_t BAR_X_L    = 10'd600;
    localparam coord_t BAR_X_R    = 10'd603;
    localparam coord_t BAR_Y_SIZE = 10'd72;
    localparam coord_t BALL_SIZE  = 10'd8;
    localparam coord_t BAR_V      = 10'd4;
    localparam coord_t BALL_V     = 10'd2;
    localparam coord_t BALL_X0    = 10'd300;
    localparam coord_t BALL_Y0    = 10'd236;

    localparam int unsigned HOLD_FRAMES = 60;
    localparam int unsigned HOLD_W      = $clog2(HOLD_FRAMES);
    typedef logic [HOLD_W-1:0] hold_t;
    localparam hold_t HOLD_LAST = hold_t'(HOLD_FRAMES - 1);

    // Derived limits, precomputed so the datapath never widens to 32 bits.
    localparam coord_t BAR_Y0    = (MAX_Y >> 1) - (BAR_Y_SIZE >> 1);
    localparam coord_t BAR_Y_MAX = MAX_Y - BAR_Y_SIZE;
    localparam coord_t BAR_EXT   = BAR_Y_SIZE - 10'd1;
    localparam coord_t BALL_EXT  = BALL_SIZE - 10'd1;
    localparam coord_t WALL_LIM  = WALL_X_R + 10'd1;
    localparam coord_t BOT_LIM   = MAX_Y - 10'd1 - BALL_V;

    localparam vel_t VEL_POS = vel_t'(BALL_V);
    localparam vel_t VEL_NEG = -VEL_POS;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        HOLD
    } state_e;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_motion_ctrl_bar.sv
// Paddle position: steps by BAR_V per frame on a single button, clamped to the screen,
// held when both or neither button is pressed or when frozen.
module pong_bar_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       freeze,
    output logic [9:0] bar_y_t
);

    coord_t bar_q;
    coord_t bar_d;

    always_comb begin
        bar_d = bar_q;
        if (refr_tick && !freeze) begin
            unique case ({btn_up, btn_down})
                2'b10:   bar_d = (bar_q > BAR_V) ? bar_q - BAR_V : '0;
                2'b01:   bar_d = (bar_q >= BAR_Y_MAX - BAR_V) ? BAR_Y_MAX : bar_q + BAR_V;
                default: bar_d = bar_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_q <= BAR_Y0;
        end else begin
            bar_q <= bar_d;
        end
    end

    assign bar_y_t = bar_q;

endmodule

// File: rtl/pong_motion_ctrl.sv
// Per-frame ball/bar motion and serve/play/miss sequencing for the pong datapath.
// Optional hit score (two BCD digits) is built only when SCORE_EN is defined.
module pong_motion_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       game_start,
    output logic [9:0] bar_y_t,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       miss,
    output logic       playing,
    output logic [7:0] score
);

    state_e state_q;
    hold_t  hold_cnt_q;
    coord_t ball_x_q, ball_y_q;
    vel_t   vx_q, vy_q;
    logic   hit_q, miss_q, playing_q;

    coord_t ball_x_d, ball_y_d;
    vel_t   vx_d, vy_d;
    coord_t ball_r, ball_b;
    logic   top_c, bot_c, wall_c, bar_c, miss_c;

    pong_bar_ctrl u_bar (
        .clk       (clk),
        .reset     (reset),
        .refr_tick (refr_tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .freeze    (state_q == HOLD),
        .bar_y_t   (bar_y_t)
    );

    // Collision rules look at the pre-update ball and bar; the new velocity applies next frame.
    always_comb begin
        ball_r = ball_x_q + BALL_EXT;
        ball_b = ball_y_q + BALL_EXT;
        top_c  = (ball_y_q <= BALL_V);
        bot_c  = (ball_b >= BOT_LIM);
        wall_c = (ball_x_q <= WALL_LIM);
        bar_c  = (ball_r >= BAR_X_L) && (ball_r <= BAR_X_R) &&
                 (ball_b >= bar_y_t) && (ball_y_q <= bar_y_t + BAR_EXT) &&
                 (vx_q > vel_t'(0));
        miss_c = !bar_c && (ball_r > BAR_X_R);

        vx_d = vx_q;
        if (wall_c) vx_d = VEL_POS;
        if (bar_c)  vx_d = VEL_NEG;

        vy_d = vy_q;
        if (top_c) vy_d = VEL_POS;
        if (bot_c) vy_d = VEL_NEG;

        ball_x_d = ball_x_q + coord_t'(vx_q);
        ball_y_d = ball_y_q + coord_t'(vy_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            ball_x_q   <= BALL_X0;
            ball_y_q   <= BALL_Y0;
            vx_q       <= VEL_POS;
            vy_q       <= VEL_POS;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            playing_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (game_start) begin
                        state_q   <= PLAY;
                        playing_q <= 1'b1;
                        vx_q      <= VEL_POS;
                        vy_q      <= VEL_POS;
                    end
                end
                PLAY: begin
                    if (refr_tick) begin
                        vx_q  <= vx_d;
                        vy_q  <= vy_d;
                        hit_q <= bar_c;
                        if (miss_c) begin
                            miss_q    <= 1'b1;
                            playing_q <= 1'b0;
                            state_q   <= HOLD;
                        end else begin
                            ball_x_q <= ball_x_d;
                            ball_y_q <= ball_y_d;
                        end
                    end
                end
                HOLD: begin
                    if (refr_tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            hold_cnt_q <= '0;
                            ball_x_q   <= BALL_X0;
                            ball_y_q   <= BALL_Y0;
                            state_q    <= IDLE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SCORE_EN
    logic [7:0] score_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else if (state_q == IDLE && game_start) begin
            score_q <= '0;
        end else if (state_q == PLAY && refr_tick && bar_c) begin
            score_q <= bcd_sat_inc(score_q);
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign hit     = hit_q;
    assign miss    = miss_q;
    assign playing = playing_q;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Scoreboard bench for pong_motion_ctrl: a frame-level game model predicts outputs,
// a separate monitor compares them whenever the design has produced a new frame.
module tb_pong_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refr_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       game_start = 1'b0;
    logic [9:0] bar_y_t, ball_x, ball_y;
    logic       hit, miss, playing;
    logic [7:0] score;

    always #5 clk = ~clk;

    pong_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .refr_tick  (refr_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .game_start (game_start),
        .bar_y_t    (bar_y_t),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit        (hit),
        .miss       (miss),
        .playing    (playing),
        .score      (score)
    );

    typedef struct {
        int bar;
        int bx;
        int by;
        bit hit;
        bit miss;
        bit playing;
        int score;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic strobe = 1'b0;
    logic strobe_d = 1'b0;
    event rst_sample;

    // Game model in frame terms
    int m_bar, m_bx, m_by, m_vx, m_vy, m_hits, m_held;
    bit m_play, m_hold, m_hit, m_miss;

    function automatic void model_reset();
        m_bar = 204; m_bx = 300; m_by = 236; m_vx = 2; m_vy = 2;
        m_hits = 0; m_held = 0; m_play = 0; m_hold = 0; m_hit = 0; m_miss = 0;
    endfunction

    function automatic void model_step(input bit tick, input bit up, input bit dn, input bit gs);
        int old_bar, right, bottom, nvx, nvy;
        bit ret, past;
        old_bar = m_bar;
        m_hit = 0;
        m_miss = 0;
        if (tick && !m_hold) begin
            if (up && !dn) m_bar = (m_bar > 4) ? m_bar - 4 : 0;
            else if (dn && !up) m_bar = (m_bar + 4 > 408) ? 408 : m_bar + 4;
        end
        if (!m_play && !m_hold) begin
            if (gs) begin
                m_play = 1; m_vx = 2; m_vy = 2; m_hits = 0;
            end
        end else if (m_play && tick) begin
            right  = m_bx + 7;
            bottom = m_by + 7;
            ret  = (right >= 600) && (right <= 603) && (bottom >= old_bar) &&
                   (m_by <= old_bar + 71) && (m_vx > 0);
            past = !ret && (right > 603);
            nvx = m_vx;
            nvy = m_vy;
            if (m_by <= 2) nvy = 2;
            if (bottom >= 477) nvy = -2;
            if (m_bx <= 36) nvx = 2;
            if (ret) begin
                nvx = -2; m_hit = 1; m_hits++;
            end
            if (past) begin
                m_miss = 1; m_play = 0; m_hold = 1; m_held = 0;
            end else begin
                m_bx += m_vx; m_by += m_vy;
            end
            m_vx = nvx;
            m_vy = nvy;
        end else if (m_hold && tick) begin
            m_held++;
            if (m_held == 60) begin
                m_hold = 0; m_bx = 300; m_by = 236;
            end
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        int s;
        e.bar = m_bar; e.bx = m_bx; e.by = m_by;
        e.hit = m_hit; e.miss = m_miss; e.playing = m_play;
`ifdef SCORE_EN
        s = (m_hits > 99) ? 99 : m_hits;
        e.score = (s / 10) * 16 + (s % 10);
`else
        s = 0;
        e.score = s;
`endif
        return e;
    endfunction

    task automatic check(input string name);
        exp_t e;
        bit ok;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s: output observed with nothing expected", name);
            return;
        end
        e = sb.pop_front();
        ok = (int'(bar_y_t) == e.bar) && (int'(ball_x) == e.bx) && (int'(ball_y) == e.by) &&
             (hit == e.hit) && (miss == e.miss) && (playing == e.playing) && (int'(score) == e.score);
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got bar=%0d ball=(%0d,%0d) hit=%0b miss=%0b play=%0b score=%h; want bar=%0d ball=(%0d,%0d) hit=%0b miss=%0b play=%0b score=%h",
                     name, $time, bar_y_t, ball_x, ball_y, hit, miss, playing, score,
                     e.bar, e.bx, e.by, e.hit, e.miss, e.playing, e.score[7:0]);
        end
    endtask

    always @(posedge clk) strobe_d <= strobe;

    always @(negedge clk) begin
        if (strobe_d) check("frame");
    end

    always @(rst_sample) check("async_reset");

    task automatic cycle(input bit tick, input bit up, input bit dn, input bit gs, input bit chk);
        @(negedge clk);
        refr_tick = tick; btn_up = up; btn_down = dn; game_start = gs; strobe = chk;
        model_step(tick, up, dn, gs);
        if (chk) sb.push_back(snap());
    endtask

    // A tick cycle plus the following cycle, so one-clock pulse width is observed.
    task automatic frame(input bit up, input bit dn, input bit gs);
        cycle(1'b1, up, dn, gs, 1'b1);
        cycle(1'b0, up, dn, 1'b0, 1'b1);
    endtask

    task automatic reset_now();
        @(negedge clk);
        refr_tick = 0; btn_up = 0; btn_down = 0; game_start = 0; strobe = 0;
        #1 reset = 1'b1;
        model_reset();
        sb.push_back(snap());
        #1 -> rst_sample;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  track_left, rallies, hits_before;
        bit  did_rst, up, dn;
        model_reset();
        track_left = 0; rallies = 0; did_rst = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  frame(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) frame(1'b0, 1'b1, 1'b0);

        for (int t = 0; t < 4000; t++) begin
            if (!did_rst && m_hold && m_held == 30) begin
                reset_now();
                did_rst = 1;
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end else if (!m_play && !m_hold) begin
                if ($urandom_range(0, 3) == 0) begin
                    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                    track_left = (rallies == 0) ? 0 : $urandom_range(0, 4);
                    rallies++;
                end else begin
                    frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                end
            end else begin
                up = 0; dn = 0;
                if (track_left > 0 && $urandom_range(0, 9) != 0) begin
                    if (m_by + 4 < m_bar + 30) up = 1;
                    else if (m_by + 4 > m_bar + 42) dn = 1;
                end else begin
                    up = 1'($urandom_range(0, 1));
                    dn = 1'($urandom_range(0, 1));
                end
                hits_before = m_hits;
                frame(up, dn, 1'($urandom_range(0, 7) == 0));
                if (m_hits != hits_before && track_left > 0) track_left--;
            end
            if ($urandom_range(0, 4) == 0) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected frames never observed, want 0", sb.size());
        n_checks++;
        if (did_rst) n_pass++;
        else $display("FAIL hold_reset: reached=%0b, want 1", did_rst);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
